// File: rtl/fetcher_pkg.sv
// Shared compute-unit types for the fetch/decode boundary.
// Default widths live here; the fetcher takes them as parameter defaults.
package fetcher_pkg;

  localparam int unsigned DefPcWidth    = 32;
  localparam int unsigned DefNumWarps   = 32;
  localparam int unsigned DefWarpWidth  = 32;
  localparam int unsigned DefInstWidth  = 32;
  localparam int unsigned DefFetchDepth = 4;
  localparam int unsigned DefWidWidth   = DefNumWarps > 1 ? $clog2(DefNumWarps) : 1;

  typedef logic [DefWidWidth-1:0]  wid_t;
  typedef logic [DefPcWidth-1:0]   pc_t;
  typedef logic [DefWarpWidth-1:0] act_mask_t;
  typedef logic [DefInstWidth-1:0] inst_t;

  typedef struct packed {
    wid_t      wid;
    pc_t       pc;
    act_mask_t act_mask;
    inst_t     inst;
  } fetch_bundle_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fetcher_rr_arbiter.sv
// Pointer-based round-robin over the warp ready bits.
// While hold_i is set the grant is pinned to hold_wid_i and the pointer freezes.
module fetcher_rr_arbiter
  import fetcher_pkg::*;
#(
  parameter int unsigned N = 32,
  localparam int unsigned W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         hold_i,
  input  logic [W-1:0] hold_wid_i,
  input  logic         advance_i,
  output logic [W-1:0] gnt_wid_o,
  output logic         gnt_valid_o
);

  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0] scan_wid;
  logic         scan_found;
  logic [W:0]   idx;

  always_comb begin
    scan_wid   = '0;
    scan_found = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr_q} + (W+1)'(i);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!scan_found && req_i[idx[W-1:0]]) begin
        scan_found = 1'b1;
        scan_wid   = idx[W-1:0];
      end
    end
  end

  assign gnt_wid_o   = hold_i ? hold_wid_i : scan_wid;
  assign gnt_valid_o = hold_i | scan_found;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) rr_ptr_d = W'(wrap_inc(32'(gnt_wid_o), N));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch: round-robin warp issue to imem, in-order response buffer,
// and valid/ready hand-off of complete bundles to the decoder.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int unsigned PcWidth    = DefPcWidth,
  parameter int unsigned NumWarps   = DefNumWarps,
  parameter int unsigned WarpWidth  = DefWarpWidth,
  parameter int unsigned InstWidth  = DefInstWidth,
  parameter int unsigned FetchDepth = DefFetchDepth,
  localparam int unsigned WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumWarps-1:0]           warp_ready_i,
  input  logic [NumWarps*PcWidth-1:0]   warp_pc_i,
  input  logic [NumWarps*WarpWidth-1:0] warp_act_mask_i,
  output logic [NumWarps-1:0]           warp_selected_o,
  output logic                          imem_req_valid_o,
  input  logic                          imem_req_ready_i,
  output logic [PcWidth-1:0]            imem_req_addr_o,
  input  logic                          imem_rsp_valid_i,
  input  logic [InstWidth-1:0]          imem_rsp_data_i,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [WidWidth-1:0]           dec_wid_o,
  output logic [PcWidth-1:0]            dec_pc_o,
  output logic [WarpWidth-1:0]          dec_act_mask_o,
  output logic [InstWidth-1:0]          dec_inst_o
);

  localparam int unsigned PtrW = $clog2(FetchDepth);
  localparam int unsigned OccW = PtrW + 1;

  typedef struct packed {
    logic [WidWidth-1:0]  wid;
    logic [PcWidth-1:0]   pc;
    logic [WarpWidth-1:0] act_mask;
    logic [InstWidth-1:0] inst;
    logic                 inst_valid;
  } entry_t;

  entry_t              buf_q [FetchDepth];
  entry_t              buf_d [FetchDepth];
  logic [PtrW-1:0]     alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic                lock_q, lock_d;
  logic [WidWidth-1:0] lock_wid_q, lock_wid_d;

  logic [WidWidth-1:0] gnt_wid;
  logic                gnt_valid;
  logic                req_valid, req_hs, pop;
  entry_t              head_ent;

  fetcher_rr_arbiter #(.N(NumWarps)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (warp_ready_i),
    .hold_i      (lock_q),
    .hold_wid_i  (lock_wid_q),
    .advance_i   (req_hs),
    .gnt_wid_o   (gnt_wid),
    .gnt_valid_o (gnt_valid)
  );

  // rst_ni gates the combinational request path so outputs read 0 during reset.
  assign req_valid        = rst_ni && gnt_valid && (occ_q < OccW'(FetchDepth));
  assign req_hs           = req_valid && imem_req_ready_i;
  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = req_valid ? warp_pc_i[gnt_wid*PcWidth +: PcWidth] : '0;
  assign warp_selected_o  = req_hs ? (NumWarps'(1) << gnt_wid) : '0;

  assign head_ent       = buf_q[head_q];
  assign dec_valid_o    = (occ_q != '0) && head_ent.inst_valid;
  assign pop            = dec_valid_o && dec_ready_i;
  assign dec_wid_o      = dec_valid_o ? head_ent.wid : '0;
  assign dec_pc_o       = dec_valid_o ? head_ent.pc : '0;
  assign dec_act_mask_o = dec_valid_o ? head_ent.act_mask : '0;
  assign dec_inst_o     = dec_valid_o ? head_ent.inst : '0;

  always_comb begin
    buf_d      = buf_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    lock_d     = lock_q;
    lock_wid_d = lock_wid_q;
    if (req_valid && !imem_req_ready_i) begin
      lock_d     = 1'b1;
      lock_wid_d = gnt_wid;
    end
    if (pop) begin
      buf_d[head_q].inst_valid = 1'b0;
      head_d = head_q + PtrW'(1);
    end
    if (imem_rsp_valid_i) begin
      buf_d[fill_q].inst       = imem_rsp_data_i;
      buf_d[fill_q].inst_valid = 1'b1;
      fill_d = fill_q + PtrW'(1);
    end
    if (req_hs) begin
      buf_d[alloc_q] = '{wid:        gnt_wid,
                         pc:         imem_req_addr_o,
                         act_mask:   warp_act_mask_i[gnt_wid*WarpWidth +: WarpWidth],
                         inst:       '0,
                         inst_valid: 1'b0};
      alloc_d = alloc_q + PtrW'(1);
      lock_d  = 1'b0;
    end
    occ_d = occ_q + OccW'(req_hs) - OccW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FetchDepth; i++) buf_q[i] <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      occ_q      <= '0;
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
    end else begin
      for (int i = 0; i < FetchDepth; i++) buf_q[i] <= buf_d[i];
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      lock_q     <= lock_d;
      lock_wid_q <= lock_wid_d;
    end
  end

`ifndef SYNTHESIS
  logic [OccW-1:0] pend_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_q + OccW'(req_hs) - OccW'(imem_rsp_valid_i);
  end

  a_sel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(warp_selected_o));
  a_sel_ready:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (warp_selected_o & ~warp_ready_i) == '0);
  a_rsp_owed:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 imem_rsp_valid_i |-> pend_q != '0);
  a_occ_max:    assert property (@(posedge clk_i) disable iff (!rst_ni) occ_q <= OccW'(FetchDepth));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 imem_req_valid_o && !imem_req_ready_i |=>
                                 imem_req_valid_o && $stable(imem_req_addr_o));
`endif

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher against a queue-based transaction model.
module tb_fetcher;

  localparam int NW = 32;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NW-1:0]   ready;
  logic [31:0]     pcs   [NW];
  logic [31:0]     masks [NW];
  logic [NW*32-1:0] warp_pc, warp_mask;
  logic [NW-1:0]   sel;
  logic            req_valid, imem_ready, rsp_valid, dec_valid, dec_ready;
  logic [31:0]     req_addr, rsp_data, dec_pc, dec_mask, dec_inst;
  logic [4:0]      dec_wid;

  always #5 clk = ~clk;

  always_comb begin
    warp_pc   = '0;
    warp_mask = '0;
    for (int i = 0; i < NW; i++) begin
      warp_pc[i*32 +: 32]   = pcs[i];
      warp_mask[i*32 +: 32] = masks[i];
    end
  end

  fetcher dut (
    .clk_i(clk), .rst_ni(rst_n),
    .warp_ready_i(ready), .warp_pc_i(warp_pc), .warp_act_mask_i(warp_mask),
    .warp_selected_o(sel),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(imem_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_wid_o(dec_wid), .dec_pc_o(dec_pc), .dec_act_mask_o(dec_mask), .dec_inst_o(dec_inst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Model state: fetches live as a list in issue order; memory as a FIFO of due times.
  typedef struct {
    int          wid;
    logic [31:0] pc;
    logic [31:0] mask;
    logic [31:0] inst;
    bit          filled;
  } ent_t;
  typedef struct {
    logic [31:0] pc;
    int          due;
  } mreq_t;

  ent_t  ents[$];
  mreq_t memq[$];
  int    rr = 0, lock_wid = 0, cyc = 0, last_due = 0;
  bit    lock = 0;

  // Stimulus knobs.
  int          ready_mode = 0;   // 0 fixed, 1 random
  logic [31:0] fixed_ready = '0;
  int          imem_mode = 0;    // 0 always, 1 low for first 3 cycles, 2 random
  int          dec_mode = 0;     // 0 always, 1 never, 2 random
  int          lat_min = 1, lat_max = 1;

  task automatic model_reset();
    ents.delete();
    memq.delete();
    rr = 0; lock = 0; lock_wid = 0; last_due = cyc;
  endtask

  task automatic step(input int phase_cyc);
    int g, occ, lat, due, idx;
    bit any, exp_v, hs, dv;
    @(posedge clk);
    #1;
    ready = (ready_mode == 0) ? fixed_ready : ($urandom & $urandom);
    if (ready_mode == 1 && $urandom_range(0, 7) == 0) ready = '0;
    if (lock) ready[lock_wid] = 1'b1;
    for (int i = 0; i < NW; i++) begin
      if (!(lock && i == lock_wid)) pcs[i] = $urandom;
      masks[i] = $urandom;
    end
    case (imem_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = (phase_cyc >= 3);
      default: imem_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (dec_mode)
      0:       dec_ready = 1'b1;
      1:       dec_ready = 1'b0;
      default: dec_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = inst_of(memq[0].pc);
      void'(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    g = 0;
    if (lock) begin
      any = 1; g = lock_wid;
    end else begin
      any = (ready != '0);
      for (int k = NW - 1; k >= 0; k--) if (ready[(rr + k) % NW]) g = (rr + k) % NW;
    end
    occ   = ents.size();
    exp_v = any && occ < FD;
    hs    = exp_v && imem_ready;
    dv    = occ > 0 && ents[0].filled;
    check_eq("req_valid", 64'(req_valid), 64'(exp_v));
    check_eq("req_addr", 64'(req_addr), exp_v ? 64'(pcs[g]) : 64'd0);
    check_eq("selected", 64'(sel), hs ? (64'd1 << g) : 64'd0);
    check_eq("dec_valid", 64'(dec_valid), 64'(dv));
    if (dv) begin
      check_eq("dec_wid", 64'(dec_wid), 64'(ents[0].wid));
      check_eq("dec_pc", 64'(dec_pc), 64'(ents[0].pc));
      check_eq("dec_mask", 64'(dec_mask), 64'(ents[0].mask));
      check_eq("dec_inst", 64'(dec_inst), 64'(ents[0].inst));
    end
    if (exp_v && !imem_ready) begin
      lock = 1; lock_wid = g;
    end
    if (rsp_valid) begin
      idx = -1;
      for (int i = ents.size() - 1; i >= 0; i--) if (!ents[i].filled) idx = i;
      if (idx >= 0) begin
        ents[idx].filled = 1;
        ents[idx].inst   = rsp_data;
      end
    end
    if (dv && dec_ready) void'(ents.pop_front());
    if (hs) begin
      ents.push_back('{wid: g, pc: pcs[g], mask: masks[g], inst: 32'd0, filled: 0});
      rr   = (g + 1) % NW;
      lock = 0;
      lat  = $urandom_range(lat_min, lat_max);
      due  = (cyc + lat > last_due) ? cyc + lat : last_due;
      memq.push_back('{pc: pcs[g], due: due});
      last_due = due;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step(c);
  endtask

  task automatic idle_inputs();
    ready = '0; imem_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; dec_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    check_eq({tag, "_req_addr"}, 64'(req_addr), 64'd0);
    check_eq({tag, "_selected"}, 64'(sel), 64'd0);
    check_eq({tag, "_dec_valid"}, 64'(dec_valid), 64'd0);
    check_eq({tag, "_dec_fields"}, 64'({dec_wid, dec_pc} | {5'd0, dec_mask | dec_inst}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      pcs[i] = 32'h1000 + i * 4; masks[i] = '1;
    end
    rst_n = 1'b0;
    ready = '1; imem_ready = 1'b1; dec_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();

    fixed_ready = 32'h5;          run(6);
    fixed_ready = 32'ha; imem_mode = 1; run(8);
    imem_mode = 0;
    fixed_ready = '1; dec_mode = 1; run(8);
    dec_mode = 0;               run(6);
    fixed_ready = 32'h7; lat_min = 5; lat_max = 5; run(16);
    fixed_ready = 32'h8000_0003; lat_min = 1; lat_max = 1; run(14);
    ready_mode = 1; imem_mode = 2; dec_mode = 2; lat_min = 1; lat_max = 4; run(3000);

    ready_mode = 0; fixed_ready = '1; imem_mode = 0; dec_mode = 1; lat_min = 3; lat_max = 3;
    run(3);
    @(posedge clk);
    #1;
    ready = '1; imem_ready = 1'b1; dec_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    dec_mode = 0; lat_min = 1; lat_max = 2;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
Instruction fetch stage directly downstream of the reconvergence stack in the compute unit. Each cycle it picks one ready warp round-robin and issues that warp's PC to instruction memory. It pulses the warp's select line back to the stack, which then holds the warp not-ready until decode. It buffers in-order memory responses together with warp metadata and hands complete fetch bundles to the decoder over a valid/ready handshake.

Parameters:
PcWidth, 32, program counter width
NumWarps, 32, warps per compute unit
WarpWidth, 32, threads per warp
InstWidth, 32, instruction word width
FetchDepth, 4, max fetches in flight plus buffered (power of two, >=2)
WidWidth, derived, NumWarps>1 ? clog2(NumWarps) : 1; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
warp_ready_i  in  NumWarps  per-warp ready, from stack
warp_pc_i  in  NumWarps*PcWidth  per-warp PC
warp_act_mask_i  in  NumWarps*WarpWidth  per-warp active mask
warp_selected_o  out  NumWarps  one-hot pulse, warp fetched this cycle
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  PcWidth  fetch address (warp PC)
imem_rsp_valid_i  in  1  response valid; in order; no backpressure
imem_rsp_data_i  in  InstWidth  fetched instruction
dec_valid_o  out  1  bundle valid to decoder
dec_ready_i  in  1  decoder accepts bundle
dec_wid_o  out  WidWidth  warp id
dec_pc_o  out  PcWidth  instruction PC
dec_act_mask_o  out  WarpWidth  active mask
dec_inst_o  out  InstWidth  instruction

Behaviour:
- Reset (async, rst_ni low): all outputs 0. Round-robin pointer = 0, lock cleared, buffer empty, occupancy 0. Reset mid-operation discards all in-flight entries; responses arriving after reset release are illegal.
- Buffer: FetchDepth entries {wid, pc, act_mask, inst, inst_valid}. Pointers: alloc, fill, head; each wraps modulo FetchDepth. occ counts allocated entries and is never more than FetchDepth.
- Arbitration: the candidate set is the warp_ready_i bits. Start at rr_ptr and grant the first set bit searching upward with wrap.
- imem_req_valid_o = (lock ? 1 : |warp_ready_i) && occ < FetchDepth. The address is the granted warp's PC.
- Lock: when valid && !imem_req_ready_i, register the granted wid and set lock. While lock is set, the grant and address come from the locked wid, and rr_ptr is frozen. Request fields stay stable until handshake.
- Handshake (valid && ready) in cycle T:
  - warp_selected_o[wid] = 1 in cycle T only, combinationally. All other bits are 0, and all bits are 0 when there is no handshake.
  - Allocate the entry at alloc with wid, pc, act_mask and inst_valid = 0.
  - alloc++, occ++, rr_ptr = wid+1 (wraps), lock cleared.
  - Throughput: one fetch per cycle.
- Response: imem_rsp_valid_i writes inst into the entry at fill, sets inst_valid and advances fill.
  - Space is guaranteed by the credit rule, so there is no ready.
  - A same-cycle response may target an entry allocated in an earlier cycle only.
- Decoder output: dec_valid_o = occ>0 && head entry inst_valid. Outputs are driven directly from the head entry, giving zero-cycle latency from fill to valid.
  - On dec_valid_o && dec_ready_i: head++, occ--, and clear inst_valid.
  - Output fields hold while valid && !ready.
- Simultaneous events:
  - Alloc and pop in the same cycle: occ unchanged.
  - At occ == FetchDepth, a pop frees the credit for the next cycle only. The request is not valid in the same cycle.
  - A response and a pop in the same cycle to different entries are both honoured. If both target the head entry, the bundle becomes valid the next cycle.
- Minimum latency, select to dec_valid_o: 1 cycle plus memory latency.
- Assertions (non-synthesis):
  - warp_selected_o is onehot0.
  - The selected warp had warp_ready_i set.
  - No response while #filled == occ.
  - occ <= FetchDepth.
  - Request fields are stable while valid && !ready.

Decomposition:
- Shared compute-unit package: wid_t, pc_t, act_mask_t, inst_t. The fetch-bundle struct {wid, pc, act_mask, inst} goes there too, reused by the decoder.
- Sub-module fetcher_rr_arbiter contains the pointer-based round-robin over NumWarps with a lock/hold input, and outputs the grant wid and valid.
- The buffer stays inline.

Test Plan:
- Ready=0b0101, imem always ready, 1-cycle response:
  - Selects warp 0, then warp 2, each as a one-cycle warp_selected_o pulse.
  - The decoder receives wid 0 then wid 2 with the correct pc and inst.
- imem_req_ready_i low 3 cycles with warps 1 and 3 ready, rr_ptr=1:
  - addr stays on warp 1's PC and warp_selected_o stays 0.
  - On ready, pulse bit 1; next grant is warp 3.
- FetchDepth=4, dec_ready_i=0, 4 warps fetched and responded:
  - Request deasserts at occ=4.
  - One dec pop re-enables the request on the next cycle.
- Responses 5 cycles late, 3 fetches outstanding:
  - Bundles emerge in issue order with matching inst.
  - dec_valid_o stays low until the head entry fills.
- Pointer wrap: issue and pop 9 fetches with FetchDepth=4 → data integrity across wrap; rr wraps from warp NumWarps-1 to 0.
- Assert rst_ni low with 2 in flight:
  - All outputs go to 0 immediately.
  - After release, the first grant starts from warp 0.
